// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-input round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = 3;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bus between the requesters and the 8:1 mux arbiter.
// master: requester side (drives req/done); slave: the arbiter.
interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    logic [N_IN-1:0]  req;
    logic             done;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_en;
    logic [N_IN-1:0]  gnt;
    logic             busy;
    logic [IDX_W-1:0] last_idx;

    modport master (
        output req, done,
        input  mux_sel, mux_en, gnt, busy, last_idx
    );

    modport slave (
        input  req, done,
        output mux_sel, mux_en, gnt, busy, last_idx
    );
endinterface

// File: rtl/mux8_rr_pick.sv
// Rotating-priority picker: first set request after last_idx, wrapping 7->0.
// Optional macro MUX8_ARB_PRIO0_EN: req[0] overrides the rotation.
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        winner = last_idx;
        valid  = 1'b0;
        cand_s = last_idx;
        for (int i = N_IN; i >= 1; i--) begin
            cand_s = last_idx + i[IDX_W-1:0];
            if (req[cand_s]) begin
                winner = cand_s;
                valid  = 1'b1;
            end else begin
            end
        end
`ifdef MUX8_ARB_PRIO0_EN
        if (req[0]) begin
            winner = 3'd0;
            valid  = 1'b1;
        end else begin
        end
`endif
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving A/EN of the gate-level 8:1 mux.
// Optional macro MUX8_ARB_PRIO0_EN: input 0 has fixed top priority and its
// grants leave the round-robin pointer untouched.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux8_rr_arbiter_if.slave      bus
);

    arb_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N_IN-1:0]  gnt_r;
    logic [SEL_W-1:0] mux_sel_r;
    logic             mux_en_r;
    logic             busy_r;
    logic [IDX_W-1:0] last_idx_r;

    logic [IDX_W-1:0] winner_s;
    logic             valid_s;
    logic             release_s;

    mux8_rr_pick u_pick (
        .req      (bus.req),
        .last_idx (last_idx_r),
        .winner   (winner_s),
        .valid    (valid_s)
    );

    // Grant ends on done, on the holder dropping its request, or on hold limit
    always_comb begin
        release_s = bus.done
                  | ~bus.req[mux_sel_r[IDX_W-1:0]]
                  | (cnt_r == CNT_W'(MAX_HOLD));
    end

    // Arbitration FSM with registered mux controls; RECOVER keeps A stable while EN=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            gnt_r      <= '0;
            mux_sel_r  <= '0;
            mux_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            last_idx_r <= 3'd7;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_s) begin
                        state_r   <= GRANT;
                        cnt_r     <= CNT_W'(1);
                        gnt_r     <= N_IN'(1) << winner_s;
                        mux_sel_r <= {1'b0, winner_s};
                        mux_en_r  <= 1'b1;
                        busy_r    <= 1'b1;
`ifdef MUX8_ARB_PRIO0_EN
                        if (winner_s != 3'd0) begin
                            last_idx_r <= winner_s;
                        end else begin
                            last_idx_r <= last_idx_r;
                        end
`else
                        last_idx_r <= winner_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r  <= RECOVER;
                        cnt_r    <= '0;
                        gnt_r    <= '0;
                        mux_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    gnt_r    <= '0;
                    mux_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.mux_sel  = mux_sel_r;
    assign bus.mux_en   = mux_en_r;
    assign bus.busy     = busy_r;
    assign bus.last_idx = last_idx_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (MAX_HOLD=4).
module tb_mux8_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux8_rr_arbiter_if bus_if ();

    mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int exp_last;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.req  = 8'h00;
        bus_if.done = 1'b0;

        // Reset values
        #12;
        chk("rst_gnt",  32'(bus_if.gnt),      32'h00);
        chk("rst_sel",  32'(bus_if.mux_sel),  32'h0);
        chk("rst_en",   32'(bus_if.mux_en),   32'h0);
        chk("rst_busy", 32'(bus_if.busy),     32'h0);
        chk("rst_last", 32'(bus_if.last_idx), 32'h7);

        // Single requester, done after 2 cycles
        rst_n = 1'b1;
        bus_if.req = 8'h01;
        step();
        chk("t1_gnt",  32'(bus_if.gnt),     32'h01);
        chk("t1_sel",  32'(bus_if.mux_sel), 32'h0);
        chk("t1_en",   32'(bus_if.mux_en),  32'h1);
        chk("t1_busy", 32'(bus_if.busy),    32'h1);
        step();
        chk("t1_hold", 32'(bus_if.gnt), 32'h01);
        bus_if.done = 1'b1;
        step();
        chk("t1_rec_en",  32'(bus_if.mux_en), 32'h0);
        chk("t1_rec_gnt", 32'(bus_if.gnt),    32'h00);
        chk("t1_rec_sel", 32'(bus_if.mux_sel), 32'h0);
        bus_if.done = 1'b0;
        bus_if.req  = 8'h00;
        step();
        chk("t1_idle_en", 32'(bus_if.mux_en), 32'h0);

        // All requesting, no done: 4-cycle grants 0..7 then wrap to 0
        do_reset();
        bus_if.req = 8'hFF;
        step();
        for (int k = 0; k <= 8; k++) begin
            w = k % 8;
            chk("t2_gnt",  32'(bus_if.gnt),      32'h1 << w);
            chk("t2_sel",  32'(bus_if.mux_sel),  32'(w));
            chk("t2_last", 32'(bus_if.last_idx), 32'(w));
            for (int c = 0; c < 3; c++) begin
                step();
                chk("t2_hold", 32'(bus_if.gnt), 32'h1 << w);
            end
            step();
            chk("t2_rec_en",  32'(bus_if.mux_en),  32'h0);
            chk("t2_rec_sel", 32'(bus_if.mux_sel), 32'(w));
            if (k == 8) bus_if.req = 8'h00;
            step();
            chk("t2_idle_busy", 32'(bus_if.busy), 32'h0);
            if (k < 8) step();
        end

        // Pointer at 2 with req 7 and 2: 7 goes first
        bus_if.req = 8'h04;
        step();
        chk("t3_pre", 32'(bus_if.gnt), 32'h04);
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        bus_if.req  = 8'h84;
        step();
        step();
        chk("t3_sel7",  32'(bus_if.mux_sel),  32'h7);
        chk("t3_gnt7",  32'(bus_if.gnt),      32'h80);
        chk("t3_last7", 32'(bus_if.last_idx), 32'h7);
        bus_if.req = 8'h04;
        step();
        chk("t3_rec", 32'(bus_if.gnt), 32'h00);
        step();
        step();
        chk("t3_gnt2", 32'(bus_if.gnt), 32'h04);

        // Request drop releases; done in IDLE/RECOVER ignored
        bus_if.req = 8'h28;
        step();
        chk("t4_drop2_en", 32'(bus_if.mux_en), 32'h0);
        step();
        step();
        chk("t4_gnt3", 32'(bus_if.gnt),     32'h08);
        chk("t4_sel3", 32'(bus_if.mux_sel), 32'h3);
        bus_if.req = 8'h20;
        step();
        chk("t4_rec_en",  32'(bus_if.mux_en),  32'h0);
        chk("t4_rec_sel", 32'(bus_if.mux_sel), 32'h3);
        bus_if.done = 1'b1;
        step();
        chk("t4_idle_en", 32'(bus_if.mux_en), 32'h0);
        step();
        chk("t4_gnt5", 32'(bus_if.gnt), 32'h20);
        bus_if.done = 1'b0;
        step();
        chk("t4_gnt5_hold", 32'(bus_if.gnt), 32'h20);

        // Asynchronous reset mid-grant
        #3 rst_n = 1'b0;
        #1;
        chk("t5_gnt",  32'(bus_if.gnt),      32'h00);
        chk("t5_en",   32'(bus_if.mux_en),   32'h0);
        chk("t5_busy", 32'(bus_if.busy),     32'h0);
        chk("t5_sel",  32'(bus_if.mux_sel),  32'h0);
        chk("t5_last", 32'(bus_if.last_idx), 32'h7);
        #2;
        bus_if.req = 8'h24;
        rst_n = 1'b1;
        step();
        chk("t5_first", 32'(bus_if.gnt), 32'h04);

        // req 0 and 4 held: alternate 0,4 (or 0 forever with priority-0 build)
        do_reset();
        bus_if.req = 8'h11;
        step();
        for (int g = 0; g < 4; g++) begin
`ifdef MUX8_ARB_PRIO0_EN
            w = 0;
            exp_last = 7;
`else
            w = (g % 2 == 1) ? 4 : 0;
            exp_last = w;
`endif
            chk("t6_gnt",  32'(bus_if.gnt),      32'h1 << w);
            chk("t6_last", 32'(bus_if.last_idx), 32'(exp_last));
            for (int c = 0; c < 4; c++) step();
            chk("t6_rec_en", 32'(bus_if.mux_en), 32'h0);
            step();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
